// File: rtl/fp_round_pack_pkg.sv
// Shared types for the fp_round_pack float packer (package fp_pkg).
// FP_ROUND_RNE_EN adds the sticky field needed for round-to-nearest-even.
package fp_pkg;
   localparam int MAG_W = 11;
   localparam int EXP_W = 3;
   localparam int SIG_W = 4;
   localparam int E_MAX = 2**EXP_W - 1;
   localparam int FP_W  = 1 + EXP_W + SIG_W;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
   } fp8_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SIG_W-1:0] sig;
      logic             r;
`ifdef FP_ROUND_RNE_EN
      logic             sticky;
`endif
   } s1_t;
endpackage

// File: rtl/fp_round_pack_if.sv
// Valid/ready stream bundle for fp_round_pack: magnitude sample in, packed float out.
interface fp_round_pack_if;
   import fp_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [MAG_W-1:0] in_mag;
   logic [EXP_W-1:0] in_exp;
   logic             out_valid;
   logic             out_ready;
   logic [FP_W-1:0]  out_fp;
   logic             out_sat;

   modport master (
      output in_valid, in_sign, in_mag, in_exp, out_ready,
      input  in_ready, out_valid, out_fp, out_sat
   );

   modport slave (
      input  in_valid, in_sign, in_mag, in_exp, out_ready,
      output in_ready, out_valid, out_fp, out_sat
   );
endinterface

// File: rtl/fp_round_pack_round.sv
// fp_round: combinational round, exponent carry and saturation of a stage-1 sample.
// FP_ROUND_RNE_EN selects round-to-nearest-even instead of round-half-up.
module fp_round
   import fp_pkg::*;
(
   input  s1_t  s1,
   output fp8_t fp,
   output logic sat
);

   function automatic logic round_up(input s1_t s);
`ifdef FP_ROUND_RNE_EN
      return s.r && (s.sticky || s.sig[0]);
`else
      return s.r;
`endif
   endfunction

   always_comb begin
      fp.sign = s1.sign;
      fp.exp  = s1.exp;
      fp.sig  = s1.sig;
      sat     = 1'b0;
      if (round_up(s1)) begin
         if (s1.sig == {SIG_W{1'b1}}) begin
            // At E_MAX the all-ones significand is already the clamp value
            if (s1.exp == EXP_W'(E_MAX)) begin
               sat = 1'b1;
            end else begin
               fp.sig = {1'b1, {(SIG_W-1){1'b0}}};
               fp.exp = s1.exp + 1'b1;
            end
         end else begin
            fp.sig = s1.sig + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_round_pack.sv
// fp_round_pack: two-stage valid/ready pipeline extracting, rounding and packing an 8-bit float.
// Build option FP_ROUND_RNE_EN enables round-to-nearest-even.
module fp_round_pack
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   fp_round_pack_if.slave    bus
);

   logic           vld_p1;
   s1_t            s1_p1;
   s1_t            s1_d;
   logic           vld_p2;
   fp8_t           fp_p2;
   logic           sat_p2;
   fp8_t           fp_d;
   logic           sat_d;
   logic           accept;
   logic           advance;
   logic [SIG_W:0] fr;

   assign bus.in_ready = !vld_p1 || !vld_p2 || bus.out_ready;
   assign accept       = bus.in_valid && bus.in_ready;
   assign advance      = vld_p1 && (!vld_p2 || bus.out_ready);

   // Appending a zero below the LSB makes the round bit fall out as 0 when E==0
   assign fr = (SIG_W+1)'({bus.in_mag, 1'b0} >> bus.in_exp);

`ifdef FP_ROUND_RNE_EN
   logic [MAG_W-1:0] sticky_mask;
   assign sticky_mask = (~({MAG_W{1'b1}} << bus.in_exp)) >> 1;
`endif

   always_comb begin
      s1_d.sign   = bus.in_sign;
      s1_d.exp    = bus.in_exp;
      s1_d.sig    = fr[SIG_W:1];
      s1_d.r      = fr[0];
`ifdef FP_ROUND_RNE_EN
      s1_d.sticky = |(bus.in_mag & sticky_mask);
`endif
   end

   // ---- stage 1 register ----
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_p1 <= s1_d;
      end
   end

   fp_round u_round (
      .s1  (s1_p1),
      .fp  (fp_d),
      .sat (sat_d)
   );

   // ---- stage 2 / output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         fp_p2  <= '0;
         sat_p2 <= 1'b0;
      end else begin
         if (accept) begin
            vld_p1 <= 1'b1;
         end else if (advance) begin
            vld_p1 <= 1'b0;
         end
         if (advance) begin
            vld_p2 <= 1'b1;
            fp_p2  <= fp_d;
            sat_p2 <= sat_d;
         end else if (bus.out_ready) begin
            vld_p2 <= 1'b0;
         end
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.out_fp    = fp_p2;
   assign bus.out_sat   = sat_p2;

endmodule

// File: tb/tb_fp_round_pack.sv
// Scoreboard bench for fp_round_pack: directed vectors, mid-stream reset and backpressure.
module tb_fp_round_pack;
   import fp_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fp_round_pack_if bus ();

   fp_round_pack dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         checks = 0;
   int         errors = 0;
   logic [8:0] expq[$];
   logic [8:0] exp_cur;
   int         occ = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: tracks accepts/drains, checks outputs, in_ready and stall stability
   initial begin
      logic       prev_stall;
      logic [8:0] prev;
      logic [8:0] got;
      logic       acc;
      logic       drn;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
            occ        = 0;
         end else begin
            if (prev_stall)
               chk("stall_hold", {23'd0, bus.out_valid, bus.out_fp, bus.out_sat}, {23'd0, 1'b1, prev});
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !(occ == 2 && !bus.out_ready)});
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (drn) begin
               got = {bus.out_fp, bus.out_sat};
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out actual=%0h required=none", got);
               end else begin
                  chk("out_fp_sat", {23'd0, got}, {23'd0, expq.pop_front()});
               end
            end
            if (acc) expq.push_back(exp_cur);
            occ        = occ + int'(acc) - int'(drn);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev       = {bus.out_fp, bus.out_sat};
         end
      end
   end

   task automatic send(input logic s, input logic [10:0] m, input logic [2:0] e,
                       input logic [7:0] f, input logic sat);
      int n;
      exp_cur      = {f, sat};
      bus.in_sign  = s;
      bus.in_mag   = m;
      bus.in_exp   = e;
      bus.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while ((expq.size() != 0 || bus.out_valid) && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
      chk("drained", expq.size(), 0);
   endtask

   logic [7:0] tie_exp;
   logic [2:0] rdy_pat[6];

   initial begin
`ifdef FP_ROUND_RNE_EN
      tie_exp = 8'b0_010_1010;
`else
      tie_exp = 8'b0_010_1011;
`endif
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_mag    = '0;
      bus.in_exp    = '0;
      bus.out_ready = 1'b1;
      exp_cur       = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_out_fp", {24'd0, bus.out_fp}, 0);
      chk("rst_out_sat", {31'd0, bus.out_sat}, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

      // Directed vectors with out_ready held high
      send(1'b1, 11'b00001101101, 3'd3, 8'b1_011_1110, 1'b0);
      send(1'b0, 11'b00000111111, 3'd2, 8'b0_011_1000, 1'b0);
      send(1'b0, 11'b11111111111, 3'd7, 8'b0_111_1111, 1'b1);
      send(1'b0, 11'b00000000101, 3'd0, 8'b0_000_0101, 1'b0);
      send(1'b0, 11'b00000101010, 3'd2, tie_exp,       1'b0);
      send(1'b0, 11'b00000101110, 3'd2, 8'b0_010_1100, 1'b0);
      send(1'b1, 11'b11111111111, 3'd7, 8'b1_111_1111, 1'b1);
      wait_empty();

      // Mid-stream reset with two samples held
      bus.out_ready = 1'b0;
      send(1'b0, 11'b00001101101, 3'd3, 8'b0_011_1110, 1'b0);
      send(1'b0, 11'b00000111111, 3'd2, 8'b0_011_1000, 1'b0);
      chk("pre_rst_valid", {31'd0, bus.out_valid}, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
      chk("midrst_out_fp", {24'd0, bus.out_fp}, 0);
      chk("midrst_out_sat", {31'd0, bus.out_sat}, 0);
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      expq.delete();
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_cur      = {8'b1_100_1101, 1'b0};
      bus.in_sign  = 1'b1;
      bus.in_mag   = 11'd201;
      bus.in_exp   = 3'd4;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk("lat_cycle1", {31'd0, bus.out_valid}, 0);
      @(posedge clk);
      #1 chk("lat_cycle2", {31'd0, bus.out_valid}, 1);
      wait_empty();

      // Backpressure streaming with out_ready pattern 1,0,0,1,0,1
      fork
         begin
            send(1'b0, 11'b00001101101, 3'd3, 8'b0_011_1110, 1'b0);
            send(1'b0, 11'b00000000101, 3'd0, 8'b0_000_0101, 1'b0);
            send(1'b0, 11'b00000111111, 3'd2, 8'b0_011_1000, 1'b0);
            send(1'b0, 11'b11111111111, 3'd7, 8'b0_111_1111, 1'b1);
            send(1'b0, 11'b10000000000, 3'd7, 8'b0_111_1000, 1'b0);
            send(1'b1, 11'd201,         3'd4, 8'b1_100_1101, 1'b0);
         end
         begin
            for (int i = 0; i < 36; i++) begin
               bus.out_ready = rdy_pat[i % 6][0];
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Downstream neighbour of the exponent/leading-zero stage in the Lab2 linear-to-floating-point converter.
- Consumes sign, 11-bit magnitude and 3-bit exponent E.
- Extracts the 4-bit significand, rounds it (round-half-up by default), handles rounding carry into E and saturation, and emits the packed 8-bit float {S,E[2:0],F[3:0]}.
- Two-stage valid/ready pipeline, so the converter can stream samples under backpressure.

Parameters:
- MAG_W, 11, magnitude width.
- EXP_W, 3, exponent width; E_MAX = 2**EXP_W-1 = 7.
- SIG_W, 4, significand width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  this block accepts a sample this cycle.
- in_sign  in  1  sign bit, passed through unchanged.
- in_mag  in  MAG_W  magnitude; upstream has already saturated 2048 to 2047.
- in_exp  in  EXP_W  exponent from the exponent stage; trusted as given, not re-derived.
- out_valid  out  1  packed result valid.
- out_ready  in  1  downstream accepts the result.
- out_fp  out  1+EXP_W+SIG_W  packed float {sign, exp, sig}.
- out_sat  out  1  rounding overflowed at E_MAX and the result was clamped.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert handled by the top level):
  - s1_valid, s2_valid, out_valid, out_sat = 0.
  - out_fp = 8'h00.
  - in_ready = 1 one cycle after deassert.
  - Reset mid-stream drops in-flight samples with no partial output.
- Handshakes:
  - Transfer occurs when valid && ready on the same edge.
  - out_valid/out_fp/out_sat hold stable while out_valid && !out_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready). Full-throughput bubble-collapsing pipeline; no combinational path from in_valid to out_valid.
- Stage 1 (register on accept):
  - Store sign, E.
  - F = in_mag[E+3:E].
  - r = (E>0) ? in_mag[E-1] : 0.
  - sticky = OR of in_mag[E-2:0] (0 when E<2).
- Stage 2 (register on advance):
  - Round up when r==1.
  - F+1 with F==4'b1111 gives F=4'b1000 and E=E+1.
  - If E==E_MAX and the round overflows, the result is F=4'b1111, E=E_MAX, out_sat=1.
  - out_sat is 0 otherwise.
- Latency: 2 cycles from accept to out_valid when out_ready is held high. Throughput 1/cycle.
- Simultaneous s2 drain and s1 refill on the same edge: both occur, no sample lost or duplicated.
- Back-to-back stalls: at most 2 samples held. in_ready falls only when both stages are full and out_ready=0.
- Sign never affects rounding (sign-magnitude).

Optional Feature:
- Macro: FP_ROUND_RNE_EN.
- When defined: round-to-nearest-even, i.e. round up iff r && (sticky || F[0]). Saturation rules unchanged.
- When undefined: round-half-up on r alone, and the sticky logic is not synthesised.

Decomposition:
- Package fp_pkg:
  - MAG_W, EXP_W, SIG_W, E_MAX localparams.
  - Packed struct fp8_t {sign, exp, sig}.
  - Struct s1_t {sign, exp, sig, r, sticky}.
- Sub-module fp_round: purely combinational round/carry/saturate of s1_t to {fp8_t, sat}. Instantiated between the stage registers.
- Top handles only handshake and registers.

Test Plan:
- Reset mid-stream: rst_n low for 3 cycles while out_valid=1 → out_valid=0 and out_fp=8'h00 immediately; first post-reset sample appears 2 cycles after accept.
- Basic round-up: mag=11'b00001101101, E=3, sign=1 → out_fp=8'b1_011_1110, out_sat=0, 2 cycles later.
- Carry into exponent: mag=11'b00000111111, E=2 → out_fp=8'b0_011_1000.
- Saturation: mag=11'b11111111111, E=7 → out_fp=8'b0_111_1111, out_sat=1. E=0 case: mag=11'b00000000101 → 8'b0_000_0101.
- Tie rounding: mag=11'b00000101010, E=2:
  - Default build → 8'b0_010_1011.
  - With FP_ROUND_RNE_EN → 8'b0_010_1010.
- Backpressure: stream 6 samples with out_ready toggling 1,0,0,1,0,1... → in_ready drops only with 2 held; outputs appear in order with no loss or duplication, and out_fp stays stable while stalled.
